// File: rtl/alarm_ringer.sv
// rtl/alarm_ringer.sv - alarm responder: beep pattern, stop/snooze/timeout, alarm_clear handshake
// Optional passive-buzzer tone generator enabled by defining ALARM_TONE_EN.
module alarm_ringer #(
    parameter int CLK_HZ         = 1000,
    parameter int BEEP_ON_TICKS  = 300,
    parameter int BEEP_OFF_TICKS = 200,
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300,
    parameter int MAX_SNOOZE     = 3,
    parameter int TONE_DIV       = 2
) (
    input  logic       newclk,
    input  logic       rst,
    input  logic       alarm_do,
    input  logic       stop,
    input  logic       snooze,
    output logic       buzzer,
    output logic       ring_led,
    output logic       ringing,
    output logic       snoozed,
    output logic       alarm_clear,
    output logic [1:0] snooze_cnt
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RING   = 2'd1;
    localparam logic [1:0] S_SNOOZE = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    localparam int TICK_W = $clog2(CLK_HZ + 1);
    localparam int BEEP_W = $clog2(BEEP_ON_TICKS + BEEP_OFF_TICKS + 1);
    localparam int RSEC_W = $clog2(RING_TIMEOUT_S + 1);
    localparam int SSEC_W = $clog2(SNOOZE_S + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_ON_TICKS + BEEP_OFF_TICKS - 1);
    localparam logic [BEEP_W-1:0] BEEP_ON   = BEEP_W'(BEEP_ON_TICKS);
    localparam logic [RSEC_W-1:0] RSEC_LAST = RSEC_W'(RING_TIMEOUT_S - 1);
    localparam logic [RSEC_W-1:0] RSEC_MAX  = RSEC_W'(RING_TIMEOUT_S);
    localparam logic [SSEC_W-1:0] SSEC_LAST = SSEC_W'(SNOOZE_S - 1);
    localparam logic [SSEC_W-1:0] SSEC_MAX  = SSEC_W'(SNOOZE_S);
    localparam logic [1:0]        SNZ_MAX   = 2'(MAX_SNOOZE);

    logic [1:0]        state;
    logic [1:0]        next_state;
    logic              stop_d;
    logic              snooze_d;
    logic              alarm_do_d;
    logic              edge_valid;
    logic [TICK_W-1:0] tick;
    logic [BEEP_W-1:0] beep_cnt;
    logic [RSEC_W-1:0] ring_sec;
    logic [SSEC_W-1:0] snz_sec;
    logic              snooze_take;
    logic              tone_gate;

    // edge_valid masks the first cycle after reset so a level that is already high is not a rise
    wire stop_rise   = edge_valid & stop & ~stop_d;
    wire snooze_rise = edge_valid & snooze & ~snooze_d;
    wire alarm_rise  = edge_valid & alarm_do & ~alarm_do_d;
    wire sec_pulse   = (tick == TICK_LAST);
    wire ring_done   = sec_pulse && (ring_sec >= RSEC_LAST);
    wire snz_done    = sec_pulse && (snz_sec >= SSEC_LAST);
    wire entering    = (next_state != state);
    wire on_phase    = (state == S_RING) && (beep_cnt < BEEP_ON);

    always_comb begin
        next_state  = state;
        snooze_take = 1'b0;
        case (state)
            S_IDLE: begin
                if (alarm_rise) next_state = S_RING;
            end
            S_RING: begin
                if (stop_rise) begin
                    next_state = S_ACK;
                end else if (snooze_rise && (snooze_cnt < SNZ_MAX)) begin
                    next_state  = S_SNOOZE;
                    snooze_take = 1'b1;
                end else if (ring_done) begin
                    next_state = S_ACK;
                end
            end
            S_SNOOZE: begin
                if (stop_rise)     next_state = S_ACK;
                else if (snz_done) next_state = S_RING;
            end
            default: begin
                if (!alarm_do) next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge newclk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            stop_d     <= 1'b0;
            snooze_d   <= 1'b0;
            alarm_do_d <= 1'b0;
            edge_valid <= 1'b0;
            tick       <= '0;
            beep_cnt   <= '0;
            ring_sec   <= '0;
            snz_sec    <= '0;
            snooze_cnt <= 2'd0;
        end else begin
            state      <= next_state;
            stop_d     <= stop;
            snooze_d   <= snooze;
            alarm_do_d <= alarm_do;
            edge_valid <= 1'b1;

            if (entering || sec_pulse) tick <= '0;
            else                       tick <= tick + TICK_W'(1);

            if (entering || (state != S_RING) || (beep_cnt == BEEP_LAST)) beep_cnt <= '0;
            else                                                          beep_cnt <= beep_cnt + BEEP_W'(1);

            if (entering)
                ring_sec <= '0;
            else if ((state == S_RING) && sec_pulse && (ring_sec != RSEC_MAX))
                ring_sec <= ring_sec + RSEC_W'(1);

            if (entering)
                snz_sec <= '0;
            else if ((state == S_SNOOZE) && sec_pulse && (snz_sec != SSEC_MAX))
                snz_sec <= snz_sec + SSEC_W'(1);

            if ((state == S_ACK) && !alarm_do) snooze_cnt <= 2'd0;
            else if (snooze_take)              snooze_cnt <= snooze_cnt + 2'd1;
        end
    end

`ifdef ALARM_TONE_EN
    localparam int TONE_W = $clog2(TONE_DIV + 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

    logic [TONE_W-1:0] tone_cnt;
    logic              tone_lvl;

    // realigned high at every beep start so each on-phase begins with the tone high
    always_ff @(posedge newclk or posedge rst) begin
        if (rst) begin
            tone_cnt <= '0;
            tone_lvl <= 1'b0;
        end else if (entering || (state != S_RING) || (beep_cnt == BEEP_LAST)) begin
            tone_cnt <= '0;
            tone_lvl <= 1'b1;
        end else if (tone_cnt == TONE_LAST) begin
            tone_cnt <= '0;
            tone_lvl <= ~tone_lvl;
        end else begin
            tone_cnt <= tone_cnt + TONE_W'(1);
        end
    end

    assign tone_gate = tone_lvl;
`else
    // active buzzer: steady drive for the whole on-phase
    assign tone_gate = (TONE_DIV > 0);
`endif

    always_ff @(posedge newclk or posedge rst) begin
        if (rst) begin
            buzzer      <= 1'b0;
            ring_led    <= 1'b0;
            ringing     <= 1'b0;
            snoozed     <= 1'b0;
            alarm_clear <= 1'b0;
        end else begin
            buzzer      <= on_phase && tone_gate;
            ring_led    <= on_phase;
            ringing     <= (state == S_RING);
            snoozed     <= (state == S_SNOOZE);
            alarm_clear <= (state == S_ACK) || ((state == S_SNOOZE) && alarm_do);
        end
    end

endmodule

// File: tb/tb_alarm_ringer.sv
// tb/tb_alarm_ringer.sv - directed self-checking bench for alarm_ringer
module tb_alarm_ringer;

    logic       newclk = 1'b0;
    logic       rst;
    logic       alarm_do;
    logic       stop;
    logic       snooze;
    logic       buzzer;
    logic       ring_led;
    logic       ringing;
    logic       snoozed;
    logic       alarm_clear;
    logic [1:0] snooze_cnt;

    int total = 0;
    int bad   = 0;

    alarm_ringer #(
        .CLK_HZ(10), .BEEP_ON_TICKS(3), .BEEP_OFF_TICKS(2),
        .RING_TIMEOUT_S(3), .SNOOZE_S(2), .MAX_SNOOZE(2), .TONE_DIV(2)
    ) dut (
        .newclk(newclk), .rst(rst), .alarm_do(alarm_do), .stop(stop), .snooze(snooze),
        .buzzer(buzzer), .ring_led(ring_led), .ringing(ringing), .snoozed(snoozed),
        .alarm_clear(alarm_clear), .snooze_cnt(snooze_cnt)
    );

    always #5 newclk = ~newclk;

    task automatic step();
        @(posedge newclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alarm_do = 1'b0; stop = 1'b0; snooze = 1'b0;
        step(); step();
        total++;
        if ({buzzer, ring_led, ringing, snoozed, alarm_clear, snooze_cnt} !== 7'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {buzzer, ring_led, ringing, snoozed, alarm_clear, snooze_cnt});
        end
        rst = 1'b0;
        step(); step();
        total++;
        if (ringing !== 1'b0) begin bad++; $display("FAIL idle_quiet: ringing=%b want 0", ringing); end
    endtask

    task automatic test_ring_pattern();
        logic exp_beep [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        int errs = 0;
        alarm_do = 1'b1;
        step();
        total++;
        if (ringing !== 1'b0) begin bad++; $display("FAIL ring_latency0: ringing=%b want 0", ringing); end
        step();
        total++;
        if (ringing !== 1'b1) begin bad++; $display("FAIL ring_latency1: ringing=%b want 1", ringing); end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            if (buzzer !== exp_beep[i] || ring_led !== exp_beep[i]) begin
                errs++;
                $display("FAIL beep_pattern[%0d]: buzzer=%b led=%b want %b", i, buzzer, ring_led, exp_beep[i]);
            end
        end
        total++;
        if (errs != 0) bad++;
    endtask

    // continues from test_ring_pattern: 10 ringing samples already observed
    task automatic test_timeout();
        int n = 10;
        for (int g = 0; g < 100; g++) begin
            step();
            if (ringing === 1'b1) n++;
            else break;
        end
        total++;
        if (n != 30) begin bad++; $display("FAIL timeout_len: ringing cycles=%0d want 30", n); end
        total++;
        if (alarm_clear !== 1'b1) begin bad++; $display("FAIL timeout_clear: alarm_clear=%b want 1", alarm_clear); end
        repeat (5) step();
        total++;
        if (alarm_clear !== 1'b1 || ringing !== 1'b0) begin
            bad++; $display("FAIL ack_hold: alarm_clear=%b ringing=%b want 1 0", alarm_clear, ringing);
        end
        alarm_do = 1'b0;
        step(); step();
        total++;
        if (alarm_clear !== 1'b0) begin bad++; $display("FAIL ack_release: alarm_clear=%b want 0", alarm_clear); end
    endtask

    task automatic test_snooze();
        int n = 1;
        alarm_do = 1'b1;
        step(); step();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        total++;
        if (snooze_cnt !== 2'd1) begin bad++; $display("FAIL snooze_cnt1: got %0d want 1", snooze_cnt); end
        step();
        total++;
        if (snoozed !== 1'b1 || buzzer !== 1'b0 || ringing !== 1'b0 || alarm_clear !== 1'b1) begin
            bad++;
            $display("FAIL snooze_enter: snoozed=%b buzzer=%b ringing=%b clear=%b want 1 0 0 1",
                     snoozed, buzzer, ringing, alarm_clear);
        end
        for (int g = 0; g < 100; g++) begin
            step();
            if (snoozed === 1'b1) n++;
            else break;
        end
        total++;
        if (n != 20) begin bad++; $display("FAIL snooze_len: snoozed cycles=%0d want 20", n); end
        total++;
        if (ringing !== 1'b1 || buzzer !== 1'b1) begin
            bad++; $display("FAIL snooze_resume: ringing=%b buzzer=%b want 1 1", ringing, buzzer);
        end
    endtask

    task automatic test_snooze_limit();
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        step();
        total++;
        if (snoozed !== 1'b1 || snooze_cnt !== 2'd2) begin
            bad++; $display("FAIL snooze2: snoozed=%b cnt=%0d want 1 2", snoozed, snooze_cnt);
        end
        for (int g = 0; g < 60; g++) begin
            step();
            if (ringing === 1'b1) break;
        end
        total++;
        if (ringing !== 1'b1) begin bad++; $display("FAIL snooze2_resume: ringing=%b want 1", ringing); end
        snooze = 1'b1;
        step();
        snooze = 1'b0;
        step(); step();
        total++;
        if (ringing !== 1'b1 || snoozed !== 1'b0 || snooze_cnt !== 2'd2) begin
            bad++;
            $display("FAIL snooze_limit: ringing=%b snoozed=%b cnt=%0d want 1 0 2", ringing, snoozed, snooze_cnt);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        total++;
        if (alarm_clear !== 1'b1 || ringing !== 1'b0) begin
            bad++; $display("FAIL stop_ack: clear=%b ringing=%b want 1 0", alarm_clear, ringing);
        end
        alarm_do = 1'b0;
        step(); step();
        total++;
        if (snooze_cnt !== 2'd0 || alarm_clear !== 1'b0) begin
            bad++; $display("FAIL event_end: cnt=%0d clear=%b want 0 0", snooze_cnt, alarm_clear);
        end
    endtask

    task automatic test_stop_snooze_same();
        alarm_do = 1'b1;
        step(); step();
        stop = 1'b1; snooze = 1'b1;
        step();
        stop = 1'b0; snooze = 1'b0;
        step();
        total++;
        if (alarm_clear !== 1'b1 || snoozed !== 1'b0 || ringing !== 1'b0 || snooze_cnt !== 2'd0) begin
            bad++;
            $display("FAIL stop_wins: clear=%b snoozed=%b ringing=%b cnt=%0d want 1 0 0 0",
                     alarm_clear, snoozed, ringing, snooze_cnt);
        end
        alarm_do = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid_ring();
        int errs = 0;
        alarm_do = 1'b1;
        step(); step();
        total++;
        if (buzzer !== 1'b1) begin bad++; $display("FAIL pre_reset_buzz: buzzer=%b want 1", buzzer); end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({buzzer, ring_led, ringing, alarm_clear} !== 4'b0) begin
            bad++; $display("FAIL async_reset: outs=%b want 0000", {buzzer, ring_led, ringing, alarm_clear});
        end
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ringing !== 1'b0) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL level_start: ringing seen %0d cycles want 0", errs); end
        alarm_do = 1'b0;
        step();
        alarm_do = 1'b1;
        step(); step();
        total++;
        if (ringing !== 1'b1) begin bad++; $display("FAIL rearm_ring: ringing=%b want 1", ringing); end
    endtask

    initial begin
        test_reset();
        test_ring_pattern();
        test_timeout();
        test_snooze();
        test_snooze_limit();
        test_stop_snooze_same();
        test_reset_mid_ring();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
